// File: rtl/eeprom_pkg.sv
// -----------------------------------------------------------------------------
// eeprom_pkg
// Shared encodings for the clocked EEPROM controller:
//   - command opcodes carried on cmd_op
//   - error codes reported on err_code
//   - controller FSM state enum
//   - a small elaboration-time helper for sizing the busy timer
// -----------------------------------------------------------------------------
package eeprom_pkg;

   // Command opcodes (cmd_op). Values 5..7 are reserved and rejected.
   localparam logic [2:0] OP_READ       = 3'd0;
   localparam logic [2:0] OP_PROG       = 3'd1;
   localparam logic [2:0] OP_ERASE_WORD = 3'd2;
   localparam logic [2:0] OP_ERASE_PAGE = 3'd3;
   localparam logic [2:0] OP_ERASE_ALL  = 3'd4;

   // Error codes (err_code).
   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_WP        = 2'd1,
      ERR_OVERWRITE = 2'd2,
      ERR_ILLEGAL   = 2'd3
   } err_e;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PROG  = 2'd1,
      ST_ERASE = 2'd2
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/eeprom_timer.sv
// -----------------------------------------------------------------------------
// eeprom_timer
// Loadable down-counter used to time program/erase operations.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load load_val into the counter (has priority over en)
//   load_val : value loaded on load
//   en       : decrement by one while the count is non-zero
//   zero     : count is zero
// -----------------------------------------------------------------------------
module eeprom_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// -----------------------------------------------------------------------------
// eeprom_ctrl
// Clocked EEPROM controller with embedded non-volatile array. Erase sets bits
// to one, program can only clear bits (stored value becomes old & wdata).
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (does not touch the array)
//   cmd_valid : command request; accepted when cmd_valid && cmd_ready
//   cmd_ready : high while idle
//   cmd_op    : 0 READ, 1 PROG, 2 ERASE_WORD, 3 ERASE_PAGE, 4 ERASE_ALL
//   cmd_addr  : word address; page = cmd_addr >> PAGE_W
//   cmd_wdata : program data
//   wp        : write protect, sampled at accept
//   rd_data   : read result, held until the next read
//   rd_valid  : one-cycle pulse, one cycle after a READ accept
//   busy      : program/erase in progress
//   done      : one-cycle pulse on the cycle after commit
//   err       : one-cycle pulse on a rejected or flagged command
//   err_code  : last error, held until the next accepted command
// -----------------------------------------------------------------------------
module eeprom_ctrl
   import eeprom_pkg::*;
#(
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 8,
   parameter int PAGE_W       = 2,
   parameter int PROG_CYCLES  = 4,
   parameter int ERASE_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic              wp,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int DEPTH      = 2 ** ADDR_W;
   localparam int MAX_CYCLES = max_int(PROG_CYCLES, ERASE_CYCLES);
   localparam int TW         = $clog2(MAX_CYCLES + 1);
   localparam logic [TW-1:0] PROG_LOAD  = TW'(PROG_CYCLES - 1);
   localparam logic [TW-1:0] ERASE_LOAD = TW'(ERASE_CYCLES - 1);

   // Non-volatile array: powers up erased and is never cleared by rst_n.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '1};

   state_e            state_reg,    state_next;
   logic [ADDR_W-1:0] addr_reg,     addr_next;
   logic [DATA_W-1:0] wdata_reg,    wdata_next;
   logic [2:0]        op_reg,       op_next;
   logic [DATA_W-1:0] rd_data_reg,  rd_data_next;
   logic              rd_valid_reg, rd_valid_next;
   logic              done_reg,     done_next;
   logic              err_reg,      err_next;
   err_e              err_code_reg, err_code_next;

   logic              accept;
   logic              commit;
   logic              overwrite;
   logic              timer_load;
   logic [TW-1:0]     timer_load_val;
   logic              timer_en;
   logic              timer_zero;

   logic [DEPTH-1:0]  word_we;
   logic [DATA_W-1:0] word_wval [DEPTH];

   assign accept    = cmd_valid && (state_reg == ST_IDLE);
   assign commit    = (state_reg != ST_IDLE) && timer_zero;
   // A program that tries to raise a cleared bit cannot do so; flag it.
   assign overwrite = |(wdata_reg & ~mem[addr_reg]);
   assign timer_en  = (state_reg != ST_IDLE);

   eeprom_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_load_val),
      .en       (timer_en),
      .zero     (timer_zero)
   );

   // Next-state and output decode.
   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      op_next        = op_reg;
      rd_data_next   = rd_data_reg;
      rd_valid_next  = 1'b0;
      done_next      = 1'b0;
      err_next       = 1'b0;
      err_code_next  = err_code_reg;
      timer_load     = 1'b0;
      timer_load_val = '0;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               err_code_next = ERR_NONE;
               case (cmd_op)
                  OP_READ: begin
                     rd_data_next  = mem[cmd_addr];
                     rd_valid_next = 1'b1;
                  end
                  OP_PROG: begin
                     if (wp) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_WP;
                     end else begin
                        state_next     = ST_PROG;
                        addr_next      = cmd_addr;
                        wdata_next     = cmd_wdata;
                        op_next        = cmd_op;
                        timer_load     = 1'b1;
                        timer_load_val = PROG_LOAD;
                     end
                  end
                  OP_ERASE_WORD, OP_ERASE_PAGE, OP_ERASE_ALL: begin
                     if (wp) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_WP;
                     end else begin
                        state_next     = ST_ERASE;
                        addr_next      = cmd_addr;
                        op_next        = cmd_op;
                        timer_load     = 1'b1;
                        timer_load_val = ERASE_LOAD;
                     end
                  end
                  default: begin
                     err_next      = 1'b1;
                     err_code_next = ERR_ILLEGAL;
                  end
               endcase
            end
         end
         ST_PROG, ST_ERASE: begin
            if (timer_zero) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
               if ((state_reg == ST_PROG) && overwrite) begin
                  err_next      = 1'b1;
                  err_code_next = ERR_OVERWRITE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         op_reg       <= OP_READ;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         err_code_reg <= ERR_NONE;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         op_reg       <= op_next;
         rd_data_reg  <= rd_data_next;
         rd_valid_reg <= rd_valid_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         err_code_reg <= err_code_next;
      end
   end

   // Per-word write enables for the commit edge. Page membership is compared
   // by shifting out the in-page bits so PAGE_W == ADDR_W (one page) works.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         logic addr_hit;
         logic page_hit;
         assign addr_hit = (addr_reg == ADDR_W'(gi));
         assign page_hit = ((ADDR_W'(gi) >> PAGE_W) == (addr_reg >> PAGE_W));
         assign word_we[gi] = commit && (
               ((state_reg == ST_PROG) && addr_hit) ||
               ((state_reg == ST_ERASE) &&
                  ((op_reg == OP_ERASE_ALL) ||
                   ((op_reg == OP_ERASE_PAGE) && page_hit) ||
                   ((op_reg == OP_ERASE_WORD) && addr_hit))));
         assign word_wval[gi] = (state_reg == ST_PROG) ? (mem[gi] & wdata_reg)
                                                        : {DATA_W{1'b1}};
      end
   endgenerate

   // Array write port: no reset, contents survive rst_n.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (word_we[i]) begin
            mem[i] <= word_wval[i];
         end
      end
   end

   assign cmd_ready = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign rd_data   = rd_data_reg;
   assign rd_valid  = rd_valid_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign err_code  = err_code_reg;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eeprom_ctrl
// Directed bench for eeprom_ctrl with default parameters. Inputs change and
// outputs are sampled 1ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_eeprom_ctrl;

   localparam logic [2:0] T_READ  = 3'd0;
   localparam logic [2:0] T_PROG  = 3'd1;
   localparam logic [2:0] T_EWORD = 3'd2;
   localparam logic [2:0] T_EPAGE = 3'd3;
   localparam logic [2:0] T_EALL  = 3'd4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [3:0] cmd_addr = 4'd0;
   logic [7:0] cmd_wdata = 8'd0;
   logic       wp = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   int n_cmp  = 0;
   int n_fail = 0;

   eeprom_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .wp        (wp),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   // Present one command for exactly one accepting edge; returns 1ns after it.
   task automatic issue(input logic [2:0] op, input logic [3:0] a,
                        input logic [7:0] d, input logic w);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (n >= 100) begin
         n_fail++;
         $display("FAIL issue_ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      end
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = d;
      wp        = w;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wp        = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a, output logic [7:0] d, output logic v);
      issue(T_READ, a, 8'h00, 1'b0);
      d = rd_data;
      v = rd_valid;
      $display("txn READ addr=%0d rd_data=%02h rd_valid=%0b", a, d, v);
   endtask

   // Issue a program/erase and follow it until busy drops (bounded).
   task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [7:0] d,
                         output int nb, output logic dn, output logic er,
                         output logic [1:0] ec, output logic rdy_bad);
      issue(op, a, d, 1'b0);
      nb = 0;
      rdy_bad = 1'b0;
      while (busy === 1'b1 && nb < 50) begin
         if (cmd_ready !== 1'b0) rdy_bad = 1'b1;
         nb++;
         @(posedge clk); #1;
      end
      dn = done;
      er = err;
      ec = err_code;
      $display("txn op=%0d addr=%0d wdata=%02h busy_cycles=%0d done=%0b err=%0b err_code=%0d",
               op, a, d, nb, dn, er, ec);
   endtask

   task automatic test_reset();
      logic [14:0] obs;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      obs = {cmd_ready, rd_valid, busy, done, err, err_code, rd_data};
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_values: got %b, required %b", obs, 15'b100000000000000);
      end
      rst_n = 1'b1;
      $display("txn RESET released");
   endtask

   task automatic test_powerup_read();
      logic [7:0] d;
      logic v;
      for (int i = 0; i < 16; i++) begin
         do_read(4'(i), d, v);
         n_cmp++;
         if (v !== 1'b1 || d !== 8'hFF) begin
            n_fail++;
            $display("FAIL powerup_read[%0d]: rd_valid=%b rd_data=%02h, required 1/FF", i, v, d);
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (rd_valid !== 1'b0 || rd_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL rd_valid_pulse: rd_valid=%b rd_data=%02h, required 0/FF", rd_valid, rd_data);
      end
   endtask

   task automatic test_program();
      int nb;
      logic dn, er, rb, v;
      logic [1:0] ec;
      logic [7:0] d;
      run_op(T_PROG, 4'd2, 8'hAA, nb, dn, er, ec, rb);
      n_cmp++;
      if (nb !== 4 || dn !== 1'b1 || er !== 1'b0 || rb !== 1'b0) begin
         n_fail++;
         $display("FAIL prog_timing: busy=%0d done=%b err=%b ready_during_busy=%b, required 4/1/0/0", nb, dn, er, rb);
      end
      do_read(4'd2, d, v);
      n_cmp++;
      if (d !== 8'hAA || v !== 1'b1) begin
         n_fail++;
         $display("FAIL prog_read: rd_data=%02h, required AA", d);
      end
      run_op(T_PROG, 4'd2, 8'h55, nb, dn, er, ec, rb);
      n_cmp++;
      if (dn !== 1'b1 || er !== 1'b1 || ec !== 2'd2) begin
         n_fail++;
         $display("FAIL prog_overwrite: done=%b err=%b err_code=%0d, required 1/1/2", dn, er, ec);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (err !== 1'b0 || err_code !== 2'd2) begin
         n_fail++;
         $display("FAIL err_code_hold: err=%b err_code=%0d, required 0/2", err, err_code);
      end
      do_read(4'd2, d, v);
      n_cmp++;
      if (d !== 8'h00 || err_code !== 2'd0) begin
         n_fail++;
         $display("FAIL overwrite_read: rd_data=%02h err_code=%0d, required 00/0", d, err_code);
      end
   endtask

   task automatic test_page_erase();
      logic [7:0] pdata [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hCC};
      logic [3:0] paddr [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      int nb;
      logic dn, er, rb, v;
      logic [1:0] ec;
      logic [7:0] d;
      for (int i = 0; i < 5; i++) begin
         run_op(T_PROG, paddr[i], pdata[i], nb, dn, er, ec, rb);
         n_cmp++;
         if (dn !== 1'b1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL page_setup[%0d]: done=%b err=%b, required 1/0", i, dn, er);
         end
      end
      run_op(T_EPAGE, 4'd6, 8'h00, nb, dn, er, ec, rb);
      n_cmp++;
      if (nb !== 8 || dn !== 1'b1 || er !== 1'b0 || rb !== 1'b0) begin
         n_fail++;
         $display("FAIL page_erase_timing: busy=%0d done=%b err=%b ready_during_busy=%b, required 8/1/0/0", nb, dn, er, rb);
      end
      for (int i = 0; i < 5; i++) begin
         do_read(paddr[i], d, v);
         n_cmp++;
         if (d !== ((i < 4) ? 8'hFF : 8'hCC)) begin
            n_fail++;
            $display("FAIL page_erase_read[%0d]: rd_data=%02h, required %02h", paddr[i], d, (i < 4) ? 8'hFF : 8'hCC);
         end
      end
   endtask

   task automatic test_protect_illegal();
      logic [7:0] d;
      logic v;
      issue(T_PROG, 4'd15, 8'hDD, 1'b1);
      $display("txn PROG wp=1 addr=15 err=%0b err_code=%0d busy=%0b", err, err_code, busy);
      n_cmp++;
      if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wp_prog: err=%b err_code=%0d busy=%b ready=%b, required 1/1/0/1", err, err_code, busy, cmd_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wp_after: err=%b busy=%b, required 0/0", err, busy);
      end
      do_read(4'd15, d, v);
      n_cmp++;
      if (d !== 8'hFF) begin
         n_fail++;
         $display("FAIL wp_read15: rd_data=%02h, required FF", d);
      end
      issue(T_EALL, 4'd0, 8'h00, 1'b1);
      $display("txn ERASE_ALL wp=1 err=%0b err_code=%0d busy=%0b", err, err_code, busy);
      n_cmp++;
      if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wp_erase: err=%b err_code=%0d busy=%b, required 1/1/0", err, err_code, busy);
      end
      do_read(4'd2, d, v);
      n_cmp++;
      if (d !== 8'h00) begin
         n_fail++;
         $display("FAIL wp_erase_read2: rd_data=%02h, required 00", d);
      end
      issue(3'd6, 4'd0, 8'h00, 1'b0);
      $display("txn OP6 err=%0b err_code=%0d busy=%0b", err, err_code, busy);
      n_cmp++;
      if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_op: err=%b err_code=%0d busy=%b, required 1/3/0", err, err_code, busy);
      end
   endtask

   task automatic test_reset_midop();
      logic [14:0] obs;
      logic [7:0] d;
      logic v;
      int nb;
      logic dn, er, rb;
      logic [1:0] ec;
      issue(T_PROG, 4'd3, 8'h0F, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      obs = {cmd_ready, rd_valid, busy, done, err, err_code, rd_data};
      $display("txn RESET mid-program addr=3");
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}) begin
         n_fail++;
         $display("FAIL midop_reset_values: got %b, required %b", obs, 15'b100000000000000);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_read(4'd3, d, v);
      n_cmp++;
      if (d !== 8'hFF || v !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_read3: rd_data=%02h, required FF", d);
      end
      run_op(T_EALL, 4'd0, 8'h00, nb, dn, er, ec, rb);
      n_cmp++;
      if (nb !== 8 || dn !== 1'b1) begin
         n_fail++;
         $display("FAIL erase_all_timing: busy=%0d done=%b, required 8/1", nb, dn);
      end
      for (int i = 0; i < 16; i++) begin
         do_read(4'(i), d, v);
         n_cmp++;
         if (d !== 8'hFF) begin
            n_fail++;
            $display("FAIL erase_all_read[%0d]: rd_data=%02h, required FF", i, d);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int nb;
      logic dn, er, rb, v;
      logic [1:0] ec;
      logic [7:0] d;
      issue(T_PROG, 4'd9, 8'h5A, 1'b0);
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (done !== 1'b1 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done_ready: done=%b cmd_ready=%b after %0d cycles, required 1/1", done, cmd_ready, n);
      end
      cmd_op    = T_READ;
      cmd_addr  = 4'd9;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      $display("txn READ during done addr=9 rd_data=%02h rd_valid=%0b", rd_data, rd_valid);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL b2b_read: rd_valid=%b rd_data=%02h, required 1/5A", rd_valid, rd_data);
      end
      run_op(T_PROG, 4'd10, 8'h3C, nb, dn, er, ec, rb);
      run_op(T_EWORD, 4'd9, 8'h00, nb, dn, er, ec, rb);
      n_cmp++;
      if (nb !== 8 || dn !== 1'b1 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL erase_word_timing: busy=%0d done=%b err=%b, required 8/1/0", nb, dn, er);
      end
      do_read(4'd9, d, v);
      n_cmp++;
      if (d !== 8'hFF) begin
         n_fail++;
         $display("FAIL erase_word_read9: rd_data=%02h, required FF", d);
      end
      do_read(4'd10, d, v);
      n_cmp++;
      if (d !== 8'h3C) begin
         n_fail++;
         $display("FAIL erase_word_read10: rd_data=%02h, required 3C", d);
      end
   endtask

   initial begin
      test_reset();
      test_powerup_read();
      test_program();
      test_page_erase();
      test_protect_illegal();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
